// File: rtl/hu_moment_scheduler_if.sv
// Shared-divider bus between the Hu moment scheduler and an external divider.
// master issues operands and a start pulse; slave returns quotient and done.
interface hu_moment_scheduler_if;
  logic        div_start;
  logic [63:0] div_num;
  logic [63:0] div_den;
  logic [63:0] div_quot;
  logic        div_done;

  modport master (
    output div_start,
    output div_num,
    output div_den,
    input  div_quot,
    input  div_done
  );

  modport slave (
    input  div_start,
    input  div_num,
    input  div_den,
    output div_quot,
    output div_done
  );
endinterface

// File: rtl/hu_moment_scheduler.sv
// Sequences centroid and normalized-moment divides onto one shared divider,
// then forms Hu invariants 1 and 2 from the normalized moments.
module hu_moment_scheduler #(
  parameter int SCALE   = 100,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] m00,
  input  logic [23:0] m10,
  input  logic [23:0] m01,
  input  logic [23:0] u00,
  input  logic [39:0] u20,
  input  logic [39:0] u02,
  input  logic [39:0] u11,
  hu_moment_scheduler_if.master div,
  output logic [9:0]  x0,
  output logic [9:0]  y0,
  output logic [31:0] n20,
  output logic [31:0] n02,
  output logic [31:0] n11,
  output logic [31:0] hu1,
  output logic [31:0] hu2,
  output logic        hu_valid,
  output logic        busy,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_ISSUE,
    S_WAIT,
    S_HU,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [23:0] r_m00, r_m10, r_m01, r_u00;
  logic [39:0] r_u20, r_u02, r_u11;
  logic [63:0] den2;
  logic [2:0]  job;
  logic [CW-1:0] cnt;

  logic [63:0] num, den;
  logic        den_zero;
  logic        got, tmo, wr;
  logic [63:0] res;
  logic        last;

  always_comb begin
    num = '0;
    den = '0;
    unique case (job)
      3'd0: begin
        num = {40'd0, r_m10};
        den = {40'd0, r_m00};
      end
      3'd1: begin
        num = {40'd0, r_m01};
        den = {40'd0, r_m00};
      end
      3'd2: begin
        num = 64'(r_u20) * 64'(SCALE);
        den = den2;
      end
      3'd3: begin
        num = 64'(r_u02) * 64'(SCALE);
        den = den2;
      end
      3'd4: begin
        num = 64'(r_u11) * 64'(SCALE);
        den = den2;
      end
      default: ;
    endcase
  end

  assign den_zero = (den == 64'd0);
  assign last     = (job == 3'd4);

  assign got = (state == S_WAIT) && div.div_done;
  assign tmo = (state == S_WAIT) && !div.div_done
             && (cnt == CW'(TIMEOUT - 1));
  assign wr  = got || tmo
             || ((state == S_ISSUE) && den_zero);
  assign res = got ? div.div_quot : 64'd0;

  // operands are only presented while a job owns the divider
  always_comb begin
    div.div_start = (state == S_ISSUE) && !den_zero;
    div.div_num   = '0;
    div.div_den   = '0;
    if (state == S_ISSUE || state == S_WAIT) begin
      div.div_num = num;
      div.div_den = den;
    end
  end

  assign busy     = (state != S_IDLE);
  assign hu_valid = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_LATCH;
      S_LATCH: state_nx = S_ISSUE;
      S_ISSUE: begin
        if (!den_zero) state_nx = S_WAIT;
        else if (last) state_nx = S_HU;
        else           state_nx = S_ISSUE;
      end
      S_WAIT: begin
        if (wr) state_nx = last ? S_HU : S_ISSUE;
      end
      S_HU:    state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  logic [31:0] dn, dsq, n11sq;
  assign dn    = (n20 >= n02) ? n20 - n02 : n02 - n20;
  assign dsq   = dn * dn;
  assign n11sq = n11 * n11;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m00 <= '0;
      r_m10 <= '0;
      r_m01 <= '0;
      r_u00 <= '0;
      r_u20 <= '0;
      r_u02 <= '0;
      r_u11 <= '0;
      den2  <= '0;
      job   <= '0;
      cnt   <= '0;
      x0    <= '0;
      y0    <= '0;
      n20   <= '0;
      n02   <= '0;
      n11   <= '0;
      hu1   <= '0;
      hu2   <= '0;
      err   <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        r_m00 <= m00;
        r_m10 <= m10;
        r_m01 <= m01;
        r_u00 <= u00;
        r_u20 <= u20;
        r_u02 <= u02;
        r_u11 <= u11;
        err   <= 1'b0;
      end
      if (state == S_LATCH) begin
        den2 <= {16'd0, r_u00 * r_u00};
        job  <= '0;
      end
      if (state == S_ISSUE && !den_zero)
        cnt <= '0;
      else if (state == S_WAIT && !wr)
        cnt <= cnt + CW'(1);
      if (wr) begin
        unique case (job)
          3'd0: x0 <= (res > 64'd1023) ? 10'd1023 : res[9:0];
          3'd1: y0 <= (res > 64'd1023) ? 10'd1023 : res[9:0];
          3'd2: n20 <= res[31:0];
          3'd3: n02 <= res[31:0];
          3'd4: n11 <= res[31:0];
          default: ;
        endcase
        if (!got) err <= 1'b1;
        if (!last) job <= job + 3'd1;
      end
      if (state == S_HU) begin
        hu1 <= n20 + n02;
        hu2 <= dsq + (n11sq << 2);
      end
    end
  end

endmodule

// File: tb/tb_hu_moment_scheduler.sv
// Scoreboarded bench for hu_moment_scheduler with a D=3 divider model.
// Frames are queued with expected results; a monitor checks each hu_valid.
module tb_hu_moment_scheduler;

  localparam int DLAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [23:0] m00 = '0, m10 = '0, m01 = '0, u00 = '0;
  logic [39:0] u20 = '0, u02 = '0, u11 = '0;
  logic [9:0]  x0, y0;
  logic [31:0] n20, n02, n11, hu1, hu2;
  logic hu_valid, busy, err;

  hu_moment_scheduler_if dif ();

  hu_moment_scheduler #(.SCALE(100), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .m00(m00), .m10(m10), .m01(m01), .u00(u00),
    .u20(u20), .u02(u02), .u11(u11),
    .div(dif.master),
    .x0(x0), .y0(y0),
    .n20(n20), .n02(n02), .n11(n11),
    .hu1(hu1), .hu2(hu2),
    .hu_valid(hu_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  x0, y0;
    logic [31:0] n20, n02, n11, hu1, hu2;
    logic        err;
    int          lat;
    int          ndiv;
    int          t0;
    int          dbase;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int div_cnt = 0;
  bit div_en = 1'b1;
  int inj_req = 0;
  int inj_ack = 0;
  logic [63:0] q;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, longint act, longint want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  // divider model: answers D cycles after div_start
  initial begin
    dif.div_done = 1'b0;
    dif.div_quot = '0;
    forever begin
      @(negedge clk);
      dif.div_done = 1'b0;
      if (inj_req != inj_ack) begin
        inj_ack = inj_req;
        dif.div_quot = 64'd77;
        dif.div_done = 1'b1;
      end else if (dif.div_start && div_en) begin
        q = dif.div_num / dif.div_den;
        repeat (DLAT) @(negedge clk);
        dif.div_quot = q;
        dif.div_done = 1'b1;
      end
    end
  end

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (dif.div_start) div_cnt++;
      if (hu_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_hu_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("x0", x0, e.x0);
          chk("y0", y0, e.y0);
          chk("n20", n20, e.n20);
          chk("n02", n02, e.n02);
          chk("n11", n11, e.n11);
          chk("hu1", hu1, e.hu1);
          chk("hu2", hu2, e.hu2);
          chk("err", err, e.err);
          chk("div_starts", div_cnt - e.dbase, e.ndiv);
          if (e.lat != 0) chk("latency", cyc - e.t0, e.lat);
        end
      end
    end
  end

  task automatic issue(
    input logic [23:0] a00, a10, a01, b00,
    input logic [39:0] b20, b02, b11,
    input bit push, input exp_t e
  );
    exp_t x;
    x = e;
    m00 = a00; m10 = a10; m01 = a01; u00 = b00;
    u20 = b20; u02 = b02; u11 = b11;
    x.t0 = cyc;
    x.dbase = div_cnt;
    if (push) sb.push_back(x);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit dropped = 0;
    bit seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (hu_valid) begin
        seen = 1;
        break;
      end
      if (!busy) dropped = 1;
      @(negedge clk);
    end
    chk({name, "_done_seen"}, seen, 1);
    chk({name, "_busy_held"}, dropped, 0);
    @(negedge clk);
    chk({name, "_busy_after"}, busy, 0);
  endtask

  exp_t ok, zr, tm, st;

  initial begin
    ok = '{x0:300, y0:200, n20:500, n02:300, n11:100, hu1:800,
           hu2:80000, err:0, lat:23, ndiv:5, t0:0, dbase:0};
    zr = '{x0:0, y0:0, n20:500, n02:300, n11:100, hu1:800,
           hu2:80000, err:1, lat:17, ndiv:3, t0:0, dbase:0};
    tm = '{x0:0, y0:0, n20:0, n02:0, n11:0, hu1:0,
           hu2:0, err:1, lat:0, ndiv:5, t0:0, dbase:0};
    st = '{x0:1023, y0:1023, n20:500, n02:300, n11:100, hu1:800,
           hu2:80000, err:0, lat:23, ndiv:5, t0:0, dbase:0};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_x0", x0, 0);
    chk("rst_hu2", hu2, 0);
    chk("rst_err", err, 0);
    chk("rst_div_num", dif.div_num, 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(100, 30000, 20000, 100, 50000, 30000, 10000, 1, ok);
    wait_done("basic");
    repeat (3) @(negedge clk);

    issue(0, 30000, 20000, 100, 50000, 30000, 10000, 1, zr);
    wait_done("zero_m00");
    repeat (3) @(negedge clk);

    div_en = 1'b0;
    issue(100, 30000, 20000, 100, 50000, 30000, 10000, 1, tm);
    wait_done("timeout");
    chk("timeout_err_hold", err, 1);
    div_en = 1'b1;
    repeat (3) @(negedge clk);

    issue(100, 30000, 20000, 100, 50000, 30000, 10000, 1, ok);
    repeat (2) @(negedge clk);
    m10 = 24'd1000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("double_start");
    repeat (30) @(negedge clk);

    issue(1, 200000, 20000, 100, 50000, 30000, 10000, 1, st);
    wait_done("saturate");
    repeat (3) @(negedge clk);

    issue(100, 30000, 20000, 100, 50000, 30000, 10000, 0, ok);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_x0", x0, 0);
    chk("abort_y0", y0, 0);
    chk("abort_n20", n20, 0);
    chk("abort_hu1", hu1, 0);
    chk("abort_err", err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    inj_req++;
    repeat (6) @(negedge clk);
    chk("stray_busy", busy, 0);
    chk("stray_x0", x0, 0);
    issue(100, 30000, 20000, 100, 50000, 30000, 10000, 1, ok);
    wait_done("after_reset");
    repeat (10) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/hu_moment_scheduler.md
HU_MOMENT_SCHEDULER -- requirements
Module: hu_moment_scheduler

Interface
REQ-001 Parameter SCALE, default 100: fixed-point multiplier applied to central-moment numerators.
REQ-002 Parameter TIMEOUT, default 1023: maximum cycles to wait for div_done per job.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse at end of moment-accumulation window.
REQ-006 m00, m10, m01  input  24 each  raw moments, sampled on an accepted start.
REQ-007 u00  input  24  central-moment pixel count, sampled on an accepted start.
REQ-008 u20, u02, u11  input  40 each  central moments, unsigned, sampled on an accepted start.
REQ-009 div_start  output  1  one-cycle pulse that launches the shared external divider.
REQ-010 div_num, div_den  output  64 each  divider operands; held stable from div_start until div_done.
REQ-011 div_quot  input  64  divider quotient, valid in the div_done cycle.
REQ-012 div_done  input  1  one-cycle divider completion pulse.
REQ-013 x0, y0  output  10 each  centroid.
REQ-014 n20, n02, n11  output  32 each  normalized moments.
REQ-015 hu1, hu2  output  32 each  Hu invariants 1 and 2.
REQ-016 hu_valid  output  1  one-cycle pulse when all outputs are updated.
REQ-017 busy  output  1  high from the accepted start until the hu_valid cycle inclusive.
REQ-018 err  output  1  sticky per frame: set on zero denominator or timeout; cleared on the next accepted start.

Function
REQ-019 FSM states: IDLE, LATCH, ISSUE, WAIT, HU, DONE.
REQ-020 IDLE + start -> LATCH: register all inputs, set busy, clear err.
REQ-021 start is ignored when not in IDLE; no queuing.
REQ-022 LATCH: compute den2 = u00*u00 (48-bit, zero-extended to 64) in one cycle; set job index to 0; go to ISSUE.
REQ-023 Fixed job order: 0 x0=m10/m00; 1 y0=m01/m00; 2 n20=u20*SCALE/den2; 3 n02=u02*SCALE/den2; 4 n11=u11*SCALE/den2.
REQ-024 Numerators are zero-extended to 64 bits; SCALE products are truncated to 64 bits.
REQ-025 ISSUE with a nonzero denominator: drive div_num/div_den, pulse div_start for exactly one cycle, go to WAIT.
REQ-026 ISSUE with a zero denominator: issue no div_start, write result 0, set err, advance to the next job, taking 1 cycle.
REQ-027 WAIT + div_done: store the quotient. x0/y0 saturate to 1023 when div_quot > 1023; n* take div_quot[31:0]. Then advance.
REQ-028 Advance: if the job index is below 4, increment it and go to ISSUE; otherwise go to HU.
REQ-029 WAIT timeout counter: reset on entry to WAIT; if it reaches TIMEOUT without div_done, write result 0, set err, and advance.
REQ-030 A div_done arriving while not in WAIT is ignored.
REQ-031 HU: hu1 = n20+n02 mod 2^32; hu2 = |n20-n02|^2 + 4*n11^2 mod 2^32; registered in one cycle; go to DONE.
REQ-032 DONE: pulse hu_valid for one cycle, deassert busy in the following cycle, go to IDLE.
REQ-033 Latency with a divider of D cycles (div_start to div_done): start to hu_valid = 1 + 5*(1+D) + 1 + 1 cycles. With D=0 this is 8 cycles.
REQ-034 x0, y0, n*, hu* update only at the points defined above and hold between frames; err holds until the next accepted start.
REQ-035 div_start is never asserted outside ISSUE; at most one divide is outstanding.

Reset
REQ-036 On rst_n low, asynchronously: state=IDLE; all outputs 0; div_num=div_den=0; internal registers 0.
REQ-037 Reset mid-operation aborts the frame: no hu_valid is produced, and a late div_done after reset release is ignored.
REQ-038 The first start after reset release is accepted normally.

Verification
REQ-039 Use a divider model with D=3. Stimulus: m00=100, m10=30000, m01=20000, u00=100, u20=50000, u02=30000, u11=10000. Required: x0=300, y0=200, n20=500, n02=300, n11=100, hu1=800, hu2=80000, err=0, hu_valid 23 cycles after start.
REQ-040 m00=0 (other inputs as in REQ-039) -> x0=0, y0=0, no div_start for jobs 0/1, err=1, n* still computed.
REQ-041 Divider never returns div_done, TIMEOUT=15 -> every result 0, err=1, hu_valid after 5 timeouts.
REQ-042 Second start pulse during WAIT -> ignored; exactly one hu_valid; busy stays high throughout.
REQ-043 rst_n asserted during job 2 WAIT -> all outputs 0 immediately; stray div_done after release is ignored; the next start completes correctly.
REQ-044 m10=200000, m00=1 -> x0 saturates to 1023.
